// File: rtl/test_cmd_ctrl.sv
// test_cmd_ctrl: serial test-mode command decoder.
// Shifts 16-bit frames (opcode, operand) in MSB first while a0_csbar is low,
// then updates analog trim, issues EEPROM requests or leaves test mode.
// Optional feature macro: TRIM_READBACK_EN (opcode 0x20 arms a 16-bit trim
// readback shifted out on sdo during the following frame).
module test_cmd_ctrl (
    input  logic        mode_cfg_clk,
    input  logic        por_rst_n,
    input  logic        test_en,
    input  logic        a0_csbar,
    input  logic        a2_wpbar,
    input  logic        ee_wbusy_comb,
    input  logic        ee_ack,
    output logic        ee_req,
    output logic [1:0]  ee_op,
    output logic [7:0]  ee_data,
    output logic [15:0] trim_reg,
    output logic        test_disable,
    output logic        cmd_err,
    output logic        sdo
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        DECODE  = 3'd2,
        EE_HOLD = 3'd3,
        EE_REQ  = 3'd4
    } state_t;

    localparam logic [4:0] CNT_FULL = 5'd16;
    localparam logic [4:0] CNT_SAT  = 5'd17;

    state_t      state_q, state_d;
    logic [15:0] frame_q, frame_d;
    logic [4:0]  count_q, count_d;
    logic [7:0]  trim_lo_q, trim_lo_d;
    logic [7:0]  trim_hi_q, trim_hi_d;
    logic [1:0]  ee_op_q, ee_op_d;
    logic [7:0]  ee_data_q, ee_data_d;
    logic        test_disable_q, test_disable_d;
    logic        cmd_err_q, cmd_err_d;
`ifdef TRIM_READBACK_EN
    logic [15:0] rb_q, rb_d;
`endif

    logic        shift_en;
    logic        frame_state;
    logic [7:0]  opcode;
    logic [7:0]  operand;

    assign shift_en    = test_en & ~a0_csbar;
    assign frame_state = (state_q == IDLE) || (state_q == SHIFT);
    assign opcode      = frame_q[15:8];
    assign operand     = frame_q[7:0];

    // Register all state; reset is synchronous and active-low.
    always_ff @(posedge mode_cfg_clk) begin
        if (!por_rst_n) begin
            state_q        <= IDLE;
            frame_q        <= 16'h0000;
            count_q        <= 5'd0;
            trim_lo_q      <= 8'h00;
            trim_hi_q      <= 8'h00;
            ee_op_q        <= 2'b00;
            ee_data_q      <= 8'h00;
            test_disable_q <= 1'b0;
            cmd_err_q      <= 1'b0;
`ifdef TRIM_READBACK_EN
            rb_q           <= 16'h0000;
`endif
        end else begin
            state_q        <= state_d;
            frame_q        <= frame_d;
            count_q        <= count_d;
            trim_lo_q      <= trim_lo_d;
            trim_hi_q      <= trim_hi_d;
            ee_op_q        <= ee_op_d;
            ee_data_q      <= ee_data_d;
            test_disable_q <= test_disable_d;
            cmd_err_q      <= cmd_err_d;
`ifdef TRIM_READBACK_EN
            rb_q           <= rb_d;
`endif
        end
    end

    // Next-state logic; dropping test_en forces IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (shift_en) state_d = SHIFT;
            end
            SHIFT: begin
                if (a0_csbar) state_d = (count_q == CNT_FULL) ? DECODE : IDLE;
            end
            DECODE: begin
                if (opcode == 8'h10 || opcode == 8'h11 || opcode == 8'h12)
                    state_d = EE_HOLD;
                else
                    state_d = IDLE;
            end
            EE_HOLD: begin
                if (!ee_wbusy_comb) state_d = EE_REQ;
            end
            EE_REQ: begin
                if (ee_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!test_en) state_d = IDLE;
    end

    // Datapath: frame shifting, length check and opcode actions in DECODE.
    always_comb begin
        frame_d        = frame_q;
        count_d        = count_q;
        trim_lo_d      = trim_lo_q;
        trim_hi_d      = trim_hi_q;
        ee_op_d        = ee_op_q;
        ee_data_d      = ee_data_q;
        test_disable_d = 1'b0;
        cmd_err_d      = cmd_err_q;
`ifdef TRIM_READBACK_EN
        rb_d           = rb_q;
        if (frame_state && shift_en) rb_d = {rb_q[14:0], 1'b0};
`endif

        if (frame_state && shift_en) begin
            frame_d = {frame_q[14:0], a2_wpbar};
            if (state_q == IDLE)
                count_d = 5'd1;
            else if (count_q != CNT_SAT)
                count_d = count_q + 5'd1;
        end

        if (state_q == SHIFT && test_en && a0_csbar) begin
            count_d = 5'd0;
            if (count_q != CNT_FULL) cmd_err_d = 1'b1;
        end

        if (state_q == DECODE && test_en) begin
            case (opcode)
                8'h01: trim_lo_d = operand;
                8'h02: trim_hi_d = operand;
                8'h10: begin ee_op_d = 2'b00; ee_data_d = operand; end
                8'h11: begin ee_op_d = 2'b01; ee_data_d = operand; end
                8'h12: begin ee_op_d = 2'b10; ee_data_d = operand; end
                8'h3C: begin
                    test_disable_d = 1'b1;
                    cmd_err_d      = 1'b0;
                end
`ifdef TRIM_READBACK_EN
                8'h20: rb_d = {trim_hi_q, trim_lo_q};
`endif
                default: cmd_err_d = 1'b1;
            endcase
        end

        if (!test_en) count_d = 5'd0;
    end

    // Outputs: ee_req follows the EE_REQ state, the rest come from flops.
    always_comb begin
        ee_req       = (state_q == EE_REQ);
        ee_op        = ee_op_q;
        ee_data      = ee_data_q;
        trim_reg     = {trim_hi_q, trim_lo_q};
        test_disable = test_disable_q;
        cmd_err      = cmd_err_q;
`ifdef TRIM_READBACK_EN
        sdo          = rb_q[15];
`else
        sdo          = 1'b0;
`endif
    end

endmodule

// File: doc/test_cmd_ctrl.md
TEST_CMD_CTRL -- requirements
Module: test_cmd_ctrl

Interface
REQ-001 SHALL have port: mode_cfg_clk  in  1  single block clock, all logic on rising edge.
REQ-002 SHALL have port: por_rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port: test_en  in  1  test mode active; block is inert while low.
REQ-004 SHALL have port: a0_csbar  in  1  frame select, active-low.
REQ-005 SHALL have port: a2_wpbar  in  1  serial command/data in, MSB first.
REQ-006 SHALL have port: ee_wbusy_comb  in  1  EEPROM write busy.
REQ-007 SHALL have port: ee_ack  in  1  EEPROM controller accepted request.
REQ-008 SHALL have port: ee_req  out  1  EEPROM operation request, level.
REQ-009 SHALL have port: ee_op  out  2  operation code: 00 erase, 01 program, 10 read.
REQ-010 SHALL have port: ee_data  out  8  data byte for program.
REQ-011 SHALL have port: trim_reg  out  16  analog trim {trim_hi,trim_lo}.
REQ-012 SHALL have port: test_disable  out  1  one-cycle pulse to leave test mode.
REQ-013 SHALL have port: cmd_err  out  1  sticky bad-frame/opcode flag.
REQ-014 SHALL have port: sdo  out  1  serial readback data.

Function
REQ-015 SHALL implement states IDLE, SHIFT, DECODE, EE_HOLD, EE_REQ.
REQ-016 IDLE->SHIFT when test_en=1 and a0_csbar=0 sampled; that cycle's a2_wpbar SHALL be bit 15.
REQ-017 SHIFT: each cycle with a0_csbar=0 shifts a2_wpbar into 16-bit frame register; 5-bit counter saturates at 17.
REQ-018 SHIFT with a0_csbar=1 sampled: count==16 -> DECODE; otherwise -> IDLE, set cmd_err, frame discarded.
REQ-019 Frame: bits[15:8] opcode, bits[7:0] operand.
REQ-020 DECODE (one cycle) opcodes: 0x01 trim_lo<=operand; 0x02 trim_hi<=operand; 0x10/0x11/0x12 -> EE_HOLD with ee_op 00/01/10, ee_data<=operand; 0x3C -> test_disable pulse; other -> set cmd_err.
REQ-021 Latency: a0_csbar rise sampled at cycle N -> DECODE at N+1 -> trim_reg/test_disable/ee_op visible at N+2; non-EE opcodes return to IDLE at N+2.
REQ-022 test_disable SHALL be high exactly one cycle per 0x3C frame.
REQ-023 EE_HOLD: wait while ee_wbusy_comb=1; on ee_wbusy_comb=0 -> EE_REQ.
REQ-024 EE_REQ: ee_req=1 held until ee_ack=1 sampled; ee_req deasserts next cycle, state -> IDLE.
REQ-025 ee_op and ee_data SHALL remain stable while ee_req=1.
REQ-026 Frames arriving during EE_HOLD/EE_REQ SHALL be ignored (no shift, no cmd_err).
REQ-027 test_en=0 in any state -> IDLE next cycle, ee_req=0, frame counter cleared; trim_reg, cmd_err retained.
REQ-028 cmd_err cleared only by reset or a valid 0x3C frame (clear and test_disable in same cycle).
REQ-029 test_en=0 and a0_csbar=0 simultaneously: no shift occurs.

Reset
REQ-030 por_rst_n=0 at a clock edge: state=IDLE, trim_reg=16'h0000, ee_req=0, ee_op=00, ee_data=0, test_disable=0, cmd_err=0, sdo=0, counter=0.
REQ-031 Reset mid-frame or mid-request SHALL abort with no further ee_req.

Configuration
REQ-032 Macro TRIM_READBACK_EN: when defined, opcode 0x20 in DECODE loads 16-bit readback register with trim_reg; during the next frame sdo drives its MSB, left-shifting one bit per sampled a0_csbar=0 cycle, zero-filled; frame otherwise decoded normally.
REQ-033 Without TRIM_READBACK_EN: sdo tied 0, no readback register, opcode 0x20 sets cmd_err.

Verification
REQ-034 test_en=1, frame 0x01A5 then 0x025A -> trim_reg=16'h5AA5 two cycles after each a0_csbar rise.
REQ-035 Frame 0x11C3 with ee_wbusy_comb=1 for 5 cycles -> ee_req stays 0, then ee_req=1, ee_op=01, ee_data=8'hC3 until ee_ack, deasserts next cycle.
REQ-036 12-bit frame, then 18-bit frame -> cmd_err=1, trim_reg unchanged; then frame 0x3C00 -> single-cycle test_disable, cmd_err=0.
REQ-037 test_en dropped during EE_REQ -> ee_req=0 next cycle, state IDLE, later ee_ack ignored.
REQ-038 With TRIM_READBACK_EN, trim_reg=16'h5AA5, frame 0x2000 then any 16-bit frame -> sdo=0101101010100101; without macro 0x2000 -> cmd_err=1, sdo=0.
REQ-039 Reset asserted mid-frame after 8 bits -> all outputs at REQ-030 values, next full frame 0x0177 decoded normally.
